// File: rtl/imem_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_responder_pkg
// Description : Shared widths, squash word and log2 helper for the
//               instruction-memory fetch responder.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_fetch_responder_pkg;

  localparam int WORD_W  = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  // Response entry layout: {err, addr, data}
  localparam int ENTRY_W = 1 + WORD_W + WORD_W;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_responder_if
// Description : Fetch-side request/response, flush and program-load bundle.
//               master = fetch stage / loader, slave = responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_responder_if;
  import imem_fetch_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [WORD_W-1:0] req_addr;

  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_data;
  logic [WORD_W-1:0] resp_addr;
  logic              resp_err;

  logic              flush;

  logic              wr_en;
  logic [WORD_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output req_valid, req_addr, resp_ready, flush, wr_en, wr_addr, wr_data,
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, flush, wr_en, wr_addr, wr_data,
    output req_ready, resp_valid, resp_data, resp_addr, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/imem_fetch_responder_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_responder_resp_fifo
// Description : Synchronous circular FIFO holding {err, addr, data} response
//               entries. Head is presented combinationally; clear empties it.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_responder_resp_fifo
  import imem_fetch_responder_pkg::*;
#(
  parameter  int WIDTH = ENTRY_W,
  parameter  int DEPTH = 4,
  localparam int CNT_W = log2_ceil(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? log2_ceil(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  // Entry storage: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Wrap-around pointers and occupancy; clear discards everything.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_responder
// Description : Instruction-memory responder. Word array with fixed read
//               latency, credit-based request acceptance, in-order buffered
//               responses, flush squash and a program-load write port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  imem_fetch_responder_if.slave       fetch_if
);

  localparam int AW    = log2_ceil(DEPTH);
  localparam int CNT_W = log2_ceil(BUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [CNT_W-1:0]   inflight_q;
  logic [CNT_W-1:0]   inflight_d;

  logic               w_acc;
  logic               w_req_err;
  logic [AW-1:0]      w_req_idx;
  logic [WORD_W-1:0]  w_rd_word;
  logic               w_wr_err;
  logic [AW-1:0]      w_wr_idx;
  logic               w_push;
  logic [ENTRY_W-1:0] w_push_entry;
  logic               w_pop;
  logic               w_resp_valid;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_credit_ok;

  // Any address bit above the index makes the access out of range.
  assign w_req_idx = fetch_if.req_addr[AW-1:0];
  assign w_req_err = (fetch_if.req_addr >> AW) != '0;
  assign w_wr_idx  = fetch_if.wr_addr[AW-1:0];
  assign w_wr_err  = (fetch_if.wr_addr >> AW) != '0;
  assign w_rd_word = w_req_err ? NOP_WORD : mem_q[w_req_idx];

  // Credit: every accepted request already owns a buffer slot.
  assign w_credit_ok = ({1'b0, inflight_q} + {1'b0, w_count}) < SUM_W'(BUF_DEPTH);
  assign fetch_if.req_ready = ~fetch_if.flush & ~rst & ~w_full & w_credit_ok;
  assign w_acc = fetch_if.req_valid & fetch_if.req_ready;

  // Program-load port; non-blocking write keeps same-cycle reads read-first.
  always_ff @(posedge clk) begin
    if (fetch_if.wr_en && !w_wr_err) mem_q[w_wr_idx] <= fetch_if.wr_data;
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat_direct
      // Single-cycle read: the buffer slot itself is the registered output.
      assign w_push       = w_acc;
      assign w_push_entry = {w_req_err, fetch_if.req_addr, w_rd_word};
    end else begin : g_lat_pipe
      localparam int STAGES = READ_LATENCY - 1;
      logic [STAGES-1:0]  st_valid_q;
      logic [ENTRY_W-1:0] st_entry_q [STAGES];

      // Stage valids; flush/reset squash everything in flight.
      always_ff @(posedge clk) begin
        if (rst || fetch_if.flush) begin
          st_valid_q <= '0;
        end else begin
          st_valid_q[0] <= w_acc;
          for (int s = 1; s < STAGES; s++) st_valid_q[s] <= st_valid_q[s-1];
        end
      end

      // Stage payloads; the array read is registered into stage 0.
      always_ff @(posedge clk) begin
        st_entry_q[0] <= {w_req_err, fetch_if.req_addr, w_rd_word};
        for (int s = 1; s < STAGES; s++) st_entry_q[s] <= st_entry_q[s-1];
      end

      assign w_push       = st_valid_q[STAGES-1];
      assign w_push_entry = st_entry_q[STAGES-1];
    end
  endgenerate

  // Requests accepted but not yet pushed into the response buffer.
  always_comb begin
    inflight_d = inflight_q + CNT_W'(w_acc) - CNT_W'(w_push);
  end

  // Inflight counter register; flush and reset drop all outstanding work.
  always_ff @(posedge clk) begin
    if (rst || fetch_if.flush) inflight_q <= '0;
    else                       inflight_q <= inflight_d;
  end

  imem_fetch_responder_resp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (fetch_if.flush),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count),
    .empty_o     (w_empty),
    .full_o      (w_full)
  );

  assign w_resp_valid        = ~w_empty & ~rst;
  assign w_pop               = w_resp_valid & fetch_if.resp_ready;
  assign fetch_if.resp_valid = w_resp_valid;
  assign fetch_if.resp_err   = w_head[ENTRY_W-1];
  assign fetch_if.resp_addr  = w_head[ENTRY_W-2 -: WORD_W];
  assign fetch_if.resp_data  = w_head[WORD_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_responder
// Description : Directed self-checking bench with a response scoreboard for
//               imem_fetch_responder (DEPTH=1024, READ_LATENCY=2, BUF_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_resp  = 0;

  logic [64:0] sb [$];
  logic [31:0] model_mem [1024];

  always #5 clk = ~clk;

  imem_fetch_responder_if bus ();

  imem_fetch_responder #(
    .DEPTH        (1024),
    .READ_LATENCY (2),
    .BUF_DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare on pop, predict on accept, then apply writes.
  task automatic monitor();
    logic [64:0] e;
    logic        err;
    if (rst || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.resp_valid && bus.resp_ready) begin
        n_resp++;
        chk("resp_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_err",  bus.resp_err,  e[64]);
          chk("resp_addr", bus.resp_addr, e[63:32]);
          chk("resp_data", bus.resp_data, e[31:0]);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        err = (bus.req_addr >= 32'd1024);
        sb.push_back({err, bus.req_addr, err ? 32'h0 : model_mem[bus.req_addr[9:0]]});
      end
    end
    if (bus.wr_en && bus.wr_addr < 32'd1024) model_mem[bus.wr_addr[9:0]] = bus.wr_data;
  endtask

  task automatic cyc_end();
    @(negedge clk);
    monitor();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      cyc_end();
      next();
    end
  endtask

  task automatic issue(input logic [31:0] a, input string tag);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    cyc_end();
    chk(tag, bus.req_ready, 1'b1);
    next();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    int          base;

    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.resp_ready = 1'b0;
    bus.flush      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = 32'h0;
    bus.wr_data    = 32'h0;

    // Reset state
    cyc_end();
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_req_ready",  bus.req_ready,  1'b0);
    next();
    tick(1);
    rst = 1'b0;
    cyc_end();
    chk("post_rst_req_ready",  bus.req_ready,  1'b1);
    chk("post_rst_resp_valid", bus.resp_valid, 1'b0);
    next();

    // Program load: words 0..31
    for (int i = 0; i < 32; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = i;
      bus.wr_data = 32'hA000_0000 + i;
      tick(1);
    end
    bus.wr_en = 1'b0;

    // Test 1: back-to-back stream 0..7, latency 2, one per cycle
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = (i < 8);
      bus.req_addr  = i;
      cyc_end();
      if (i < 8) chk("t1_req_ready", bus.req_ready, 1'b1);
      chk("t1_resp_valid", bus.resp_valid, (i >= 2));
      next();
    end
    bus.req_valid = 1'b0;
    cyc_end();
    chk("t1_resp_idle", bus.resp_valid, 1'b0);
    next();
    chk("t1_sb_empty", sb.size(), 0);

    // Test 2: stall downstream, exactly 4 accepted, then resume 0..9
    bus.resp_ready = 1'b0;
    addr = 0;
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      cyc_end();
      if (bus.req_ready) addr++;
      next();
    end
    chk("t2_accepted_stalled", addr, 32'd4);
    cyc_end();
    chk("t2_full_req_ready",  bus.req_ready,  1'b0);
    chk("t2_full_resp_valid", bus.resp_valid, 1'b1);
    next();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 40 && !(addr == 10 && sb.size() == 0); k++) begin
      bus.req_valid = (addr < 10);
      bus.req_addr  = addr;
      cyc_end();
      if (bus.req_valid && bus.req_ready) addr++;
      next();
    end
    bus.req_valid = 1'b0;
    chk("t2_all_accepted", addr, 32'd10);
    chk("t2_sb_empty", sb.size(), 0);
    cyc_end();
    chk("t2_no_dup", bus.resp_valid, 1'b0);
    next();

    // Test 3: flush discards 3,4,5; only 20 returns
    bus.resp_ready = 1'b0;
    issue(32'd3, "t3_ready_3");
    issue(32'd4, "t3_ready_4");
    issue(32'd5, "t3_ready_5");
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd9;
    cyc_end();
    chk("t3_flush_req_ready", bus.req_ready, 1'b0);
    next();
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    base = n_resp;
    issue(32'd20, "t3_ready_20");
    tick(5);
    chk("t3_resp_count", n_resp - base, 1);
    chk("t3_sb_empty", sb.size(), 0);

    // Test 4: out-of-range read and ignored write
    issue(32'h0000_0400, "t4_ready_oor");
    tick(4);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 32'h0000_0400;
    bus.wr_data = 32'hFFFF_FFFF;
    tick(1);
    bus.wr_en = 1'b0;
    issue(32'd0, "t4_ready_0");
    tick(4);
    chk("t4_sb_empty", sb.size(), 0);

    // Test 5: read-first on same-cycle write
    bus.wr_en   = 1'b1;
    bus.wr_addr = 32'd5;
    bus.wr_data = 32'h1111_1111;
    tick(1);
    bus.wr_data = 32'hDEAD_BEEF;
    issue(32'd5, "t5_ready_rf");
    bus.wr_en = 1'b0;
    tick(4);
    issue(32'd5, "t5_ready_new");
    tick(4);
    chk("t5_sb_empty", sb.size(), 0);

    // Test 6: reset with buffered and in-flight responses
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) issue(32'd10 + k, "t6_ready_fill");
    rst = 1'b1;
    cyc_end();
    chk("t6_rst_resp_valid", bus.resp_valid, 1'b0);
    chk("t6_rst_req_ready",  bus.req_ready,  1'b0);
    next();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc_end();
      chk("t6_no_stale", bus.resp_valid, 1'b0);
      next();
    end
    issue(32'd6, "t6_ready_new");
    tick(4);
    chk("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
